register: RTL and testbench
===========================

REGISTER -- requirements
Module: register

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, which sets the data width in bits; legal values are WIDTH >= 1.
REQ-002 The module SHALL have parameter RESET_VALUE, default all-zeros (WIDTH bits), which is the value loaded into q_out on reset.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes except reset occur on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-005 The module SHALL have port enable, input, 1 bit: load enable, active-high.
REQ-006 The module SHALL have port d_in, input, WIDTH bits: data to load.
REQ-007 The module SHALL have port q_out, output, WIDTH bits: the registered value, driven directly from the storage flops.
REQ-008 The module SHALL have no ports other than those in REQ-003 to REQ-007.

Function
REQ-009 On each rising edge of clk with reset = 1 and enable = 1, the register SHALL capture d_in and present it on q_out after that edge.
REQ-010 On each rising edge of clk with reset = 1 and enable = 0, the register SHALL hold q_out unchanged, regardless of d_in.
REQ-011 Load latency SHALL be exactly one clock edge: the d_in value sampled at edge N appears on q_out after edge N, with no extra pipeline stage.
REQ-012 q_out SHALL be a pure register output, with no combinational path from d_in, enable or clk to q_out.
REQ-013 The register SHALL load all WIDTH bits together; it SHALL NOT support partial or byte writes.
REQ-014 The register SHALL capture d_in unmodified, with no truncation, extension or transformation.
REQ-015 Changes on d_in or enable between clock edges SHALL have no effect on q_out.
REQ-016 When enable is 1 and d_in equals the current q_out, q_out SHALL remain stable, with no glitch.

Reset
REQ-017 When reset goes to 0, q_out SHALL become RESET_VALUE immediately (asynchronously), without waiting for a clk edge.
REQ-018 While reset = 0, q_out SHALL stay at RESET_VALUE, and clk, enable and d_in SHALL be ignored.
REQ-019 Reset SHALL take priority over enable at every clock edge.
REQ-020 After reset returns to 1, the first possible load SHALL be the first rising clk edge that occurs while reset = 1 and enable = 1.
REQ-021 An assertion of reset between clock edges, in the middle of operation, SHALL discard the stored value and load RESET_VALUE.

Verification
REQ-022 The bench SHALL cover power-on reset: WIDTH=8, reset=0 for one cycle -> q_out = 0x00.
REQ-023 The bench SHALL cover a basic load: reset=1, enable=1, d_in=0xAA, one rising edge -> q_out = 0xAA.
REQ-024 The bench SHALL cover hold: then enable=0, d_in=0xFF, one rising edge -> q_out stays 0xAA.
REQ-025 The bench SHALL cover reload: then enable=1, d_in=0xCC, one rising edge -> q_out = 0xCC.
REQ-026 The bench SHALL cover asynchronous reset: with q_out = 0xCC, drive reset=0 midway between edges -> q_out = 0x00 before the next edge; with enable=1 and d_in=0x55, q_out stays 0x00 while reset=0 and becomes 0x55 on the first edge after reset=1.
REQ-027 The bench SHALL cover a parameter override: WIDTH=16, RESET_VALUE=0xBEEF, reset=0 -> q_out = 0xBEEF; then reset=1, enable=1, d_in=0x1234, one edge -> q_out = 0x1234.

Source files
------------

// File: rtl/register.sv
// Parameterised load-enable register with asynchronous active-low reset.
// q_out comes straight from the storage flops; nothing combinational follows them.
module register #(
    parameter int                 WIDTH       = 8,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Whole-word load when enabled; otherwise recirculate the stored value.
    always_comb begin
        q_d = q_q;
        if (enable) begin
            q_d = d_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_out = q_q;

endmodule

// File: tb/tb_register.sv
// Directed bench for register: an 8-bit default instance and a 16-bit instance
// with RESET_VALUE=0xBEEF, checked through an expected-value queue.
module tb_register;

    logic        clk = 1'b0;
    logic        reset8 = 1'b1;
    logic        enable8 = 1'b0;
    logic [7:0]  d8 = '0;
    logic [7:0]  q8;
    logic        reset16 = 1'b1;
    logic        enable16 = 1'b0;
    logic [15:0] d16 = '0;
    logic [15:0] q16;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [15:0] exp_q[$];
    int          sel_q[$];
    string       name_q[$];
    event        chk_ev;

    always #5 clk = ~clk;

    register u_dut8 (
        .clk    (clk),
        .reset  (reset8),
        .enable (enable8),
        .d_in   (d8),
        .q_out  (q8)
    );

    register #(
        .WIDTH       (16),
        .RESET_VALUE (16'hBEEF)
    ) u_dut16 (
        .clk    (clk),
        .reset  (reset16),
        .enable (enable16),
        .d_in   (d16),
        .q_out  (q16)
    );

    // Monitor: whenever a sample point is announced, pop and compare.
    always begin
        @(chk_ev);
        while (exp_q.size() > 0) begin
            logic [15:0] exp_v;
            logic [15:0] act_v;
            int          sel;
            string       nm;
            exp_v = exp_q.pop_front();
            sel   = sel_q.pop_front();
            nm    = name_q.pop_front();
            act_v = (sel == 16) ? q16 : {8'h00, q8};
            total_cnt++;
            if (act_v === exp_v) begin
                pass_cnt++;
            end else begin
                $display("FAIL %s: got %h expected %h", nm, act_v, exp_v);
            end
        end
    end

    task automatic expect_q(input int sel, input string nm, input logic [15:0] exp_v);
        exp_q.push_back(exp_v);
        sel_q.push_back(sel);
        name_q.push_back(nm);
        -> chk_ev;
        #0;
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        reset8  = 1'b0;
        reset16 = 1'b0;
        enable8 = 1'b1;
        d8      = 8'h77;
        step();
        expect_q(8,  "por_8", 16'h0000);
        expect_q(16, "por_16", 16'hBEEF);
        expect_q(8,  "reset_over_enable", 16'h0000);

        reset8  = 1'b1;
        d8      = 8'hAA;
        step();
        expect_q(8, "load_aa", 16'h00AA);

        enable8 = 1'b0;
        d8      = 8'hFF;
        step();
        expect_q(8, "hold_aa", 16'h00AA);

        enable8 = 1'b1;
        d8      = 8'hCC;
        step();
        expect_q(8, "reload_cc", 16'h00CC);

        d8 = 8'h3C;
        #2;
        expect_q(8, "no_mid_cycle_load", 16'h00CC);
        d8 = 8'h5A;
        step();
        expect_q(8, "last_value_at_edge", 16'h005A);

        step();
        expect_q(8, "same_value_reload", 16'h005A);

        d8 = 8'hCC;
        step();
        expect_q(8, "pre_async_cc", 16'h00CC);
        #3;
        reset8 = 1'b0;
        #1;
        expect_q(8, "async_reset_mid_cycle", 16'h0000);
        d8 = 8'h55;
        step();
        expect_q(8, "held_in_reset", 16'h0000);
        #3;
        reset8 = 1'b1;
        #1;
        expect_q(8, "release_no_load", 16'h0000);
        step();
        expect_q(8, "first_load_after_reset", 16'h0055);

        enable8 = 1'b0;
        d8      = 8'h01;
        step();
        expect_q(8, "hold_55", 16'h0055);

        reset16  = 1'b1;
        enable16 = 1'b1;
        d16      = 16'h1234;
        step();
        expect_q(16, "load_1234", 16'h1234);
        enable16 = 1'b0;
        d16      = 16'hFFFF;
        step();
        expect_q(16, "hold_1234", 16'h1234);
        #2;
        reset16 = 1'b0;
        #1;
        expect_q(16, "async_reset_16", 16'hBEEF);

        #5;
        total_cnt += exp_q.size();
        if (exp_q.size() != 0) begin
            $display("FAIL queue_drain: got %0d expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
